// File: rtl/custom_core_ctrl.sv
// Reset, boot and interrupt sequencer for the custom_cv64a6 core wrapper.
// Optional debug-request path is built when CUSTOM_CORE_CTRL_DEBUG_EN is defined.
module custom_core_ctrl #(
  parameter int unsigned           ADDR_WIDTH        = 64,
  parameter int unsigned           RST_HOLD_CYCLES   = 16,
  parameter int unsigned           SYNC_STAGES       = 2,
  parameter logic [ADDR_WIDTH-1:0] DEFAULT_BOOT_ADDR = ADDR_WIDTH'(64'h0000_0000_8000_0000)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  soft_rst_i,
  input  logic [ADDR_WIDTH-1:0] boot_addr_cfg_i,
  input  logic [ADDR_WIDTH-1:0] hart_id_cfg_i,
  input  logic [1:0]            irq_async_i,
  input  logic                  ipi_async_i,
  input  logic                  timer_async_i,
  input  logic                  debug_async_i,
  output logic                  core_rst_no,
  output logic [ADDR_WIDTH-1:0] boot_addr_o,
  output logic [ADDR_WIDTH-1:0] hart_id_o,
  output logic [1:0]            irq_o,
  output logic                  ipi_o,
  output logic                  time_irq_o,
  output logic                  debug_req_o,
  output logic                  running_o
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned NUM_INT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             latch_cfg;
  logic             run_d;

  // State and hold counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; a soft reset relatches config and restarts the hold
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_cfg = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          latch_cfg = 1'b1;
          cnt_d     = CNT_W'(RST_HOLD_CYCLES - 1);
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!start_i) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (soft_rst_i) begin
          latch_cfg = 1'b1;
          cnt_d     = CNT_W'(RST_HOLD_CYCLES - 1);
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!start_i) begin
          state_d = ST_IDLE;
        end else if (soft_rst_i) begin
          latch_cfg = 1'b1;
          cnt_d     = CNT_W'(RST_HOLD_CYCLES - 1);
          state_d   = ST_HOLD;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign run_d = (state_d == ST_RUN);

  // Core reset, run flag and latched boot configuration
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      core_rst_no <= 1'b0;
      running_o   <= 1'b0;
      boot_addr_o <= DEFAULT_BOOT_ADDR;
      hart_id_o   <= '0;
    end else begin
      core_rst_no <= run_d;
      running_o   <= run_d;
      if (latch_cfg) begin
        boot_addr_o <= boot_addr_cfg_i;
        hart_id_o   <= hart_id_cfg_i;
      end
    end
  end

  // Interrupt synchronizers; the last stage folds in the RUN mask, which
  // equals ANDing the final synchronizer flop with the registered run flag.
  logic [SYNC_STAGES-2:0][NUM_INT-1:0] int_meta;
  logic [NUM_INT-1:0]                  int_q;
  logic [NUM_INT-1:0]                  int_async;

  assign int_async = {timer_async_i, ipi_async_i, irq_async_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      int_meta <= '0;
      int_q    <= '0;
    end else begin
      int_meta[0] <= int_async;
      for (int i = 1; i < int'(SYNC_STAGES) - 1; i++) begin
        int_meta[i] <= int_meta[i-1];
      end
      int_q <= int_meta[SYNC_STAGES-2] & {NUM_INT{run_d}};
    end
  end

  assign irq_o      = int_q[1:0];
  assign ipi_o      = int_q[2];
  assign time_irq_o = int_q[3];

`ifdef CUSTOM_CORE_CTRL_DEBUG_EN
  localparam int unsigned DBG_STRETCH = 4;
  localparam int unsigned STRETCH_W   = 3;

  logic [SYNC_STAGES-2:0] dbg_meta;
  logic                   dbg_q;
  logic [STRETCH_W-1:0]   stretch_q, stretch_d;

  // Keep a debug request alive across core release so the first fetch traps
  always_comb begin
    stretch_d = stretch_q;
    if (state_q == ST_HOLD && state_d == ST_RUN && dbg_q) begin
      stretch_d = STRETCH_W'(DBG_STRETCH);
    end else if (stretch_q != '0) begin
      stretch_d = stretch_q - STRETCH_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dbg_meta  <= '0;
      dbg_q     <= 1'b0;
      stretch_q <= '0;
    end else begin
      dbg_meta[0] <= debug_async_i;
      for (int i = 1; i < int'(SYNC_STAGES) - 1; i++) begin
        dbg_meta[i] <= dbg_meta[i-1];
      end
      dbg_q     <= dbg_meta[SYNC_STAGES-2] | (stretch_d != '0);
      stretch_q <= stretch_d;
    end
  end

  assign debug_req_o = dbg_q;
`else
  logic unused_debug;
  assign unused_debug = debug_async_i;
  assign debug_req_o  = 1'b0;
`endif

endmodule
